// File: rtl/ime_pkg.sv
// Shared types and constants for the integer motion-estimation search controller.
package ime_pkg;

    localparam int NUM_PART = 9;
    localparam int P_FF     = 0;
    localparam int P_F8_0   = 1;
    localparam int P_F8_1   = 2;
    localparam int P_8F_0   = 3;
    localparam int P_8F_1   = 4;
    localparam int P_88_00  = 5;
    localparam int P_88_01  = 6;
    localparam int P_88_10  = 7;
    localparam int P_88_11  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int MV_W_DEF = 6;

    typedef struct packed {
        logic signed [MV_W_DEF-1:0] y;
        logic signed [MV_W_DEF-1:0] x;
    } mv_t;

endpackage

// File: rtl/ime_min_tracker.sv
// Single-partition running minimum of SAD with the motion vector that produced it.
module ime_min_tracker
    import ime_pkg::*;
#(
    parameter int SAD_W = 16,
    parameter int MV_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic [SAD_W-1:0]  sad,
    input  logic [2*MV_W-1:0] mv,
    output logic [SAD_W-1:0]  best_sad,
    output logic [2*MV_W-1:0] best_mv
);

    // Strict compare: on a tie the earlier raster candidate is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_sad <= '1;
            best_mv  <= '0;
        end else if (clear) begin
            best_sad <= '1;
            best_mv  <= '0;
        end else if (valid && (sad < best_sad)) begin
            best_sad <= sad;
            best_mv  <= mv;
        end
    end

endmodule

// File: rtl/ime_search_ctrl.sv
// Full-search sequencer: walks candidate MVs, rolls the PE array and tracks 9 partition minima.
module ime_search_ctrl
    import ime_pkg::*;
#(
    parameter int SR     = 8,
    parameter int MV_W   = 6,
    parameter int SAD_W  = 16,
    parameter int PE_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          ref_ready,
    input  logic [NUM_PART*SAD_W-1:0]     sad_in,
    output logic                          roll,
    output logic signed [MV_W-1:0]        cand_x,
    output logic signed [MV_W-1:0]        cand_y,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_PART*SAD_W-1:0]     best_sad,
    output logic [NUM_PART*2*MV_W-1:0]    best_mv
);

    localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-SR);
    localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(SR-1);

    state_t            state;
    logic              clear;
    logic              last;
    logic              pending;
    logic [PE_LAT-1:0] tag_v;
    logic [2*MV_W-1:0] tag_mv [PE_LAT];
    logic              head_v;
    logic [2*MV_W-1:0] head_mv;

    assign clear   = (state == IDLE) && start;
    assign roll    = (state == SEARCH) && ref_ready;
    assign last    = (cand_x == MV_MAX) && (cand_y == MV_MAX);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign head_v  = tag_v[PE_LAT-1];
    assign head_mv = tag_mv[PE_LAT-1];

    // Head entry is consumed this cycle, so only younger entries keep DRAIN alive.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < PE_LAT-1; i++) begin
            pending = pending | tag_v[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cand_x <= MV_MIN;
            cand_y <= MV_MIN;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SEARCH;
                        cand_x <= MV_MIN;
                        cand_y <= MV_MIN;
                    end
                end
                SEARCH: begin
                    if (ref_ready) begin
                        if (last) begin
                            state <= DRAIN;
                        end else if (cand_x == MV_MAX) begin
                            cand_x <= MV_MIN;
                            cand_y <= cand_y + 1'b1;
                        end else begin
                            cand_x <= cand_x + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int i = 0; i < PE_LAT; i++) begin
                tag_mv[i] <= '0;
            end
        end else begin
            tag_v[0]  <= roll;
            tag_mv[0] <= {cand_y, cand_x};
            for (int i = 1; i < PE_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_mv[i] <= tag_mv[i-1];
            end
        end
    end

    for (genvar p = 0; p < NUM_PART; p++) begin : g_part
        ime_min_tracker #(
            .SAD_W (SAD_W),
            .MV_W  (MV_W)
        ) u_trk (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .valid    (head_v),
            .sad      (sad_in[p*SAD_W +: SAD_W]),
            .mv       (head_mv),
            .best_sad (best_sad[p*SAD_W +: SAD_W]),
            .best_mv  (best_mv[p*2*MV_W +: 2*MV_W])
        );
    end

endmodule

// File: tb/tb_ime_search_ctrl.sv
// Scoreboard bench for ime_search_ctrl: candidate order, latency, minima, stalls, abort.
module tb_ime_search_ctrl;
    import ime_pkg::*;

    localparam int SR     = 8;
    localparam int MV_W   = 6;
    localparam int SAD_W  = 16;
    localparam int PE_LAT = 2;
    localparam int NCAND  = (2*SR)*(2*SR);

    typedef struct packed {
        logic [NUM_PART*SAD_W-1:0]  sad;
        logic [NUM_PART*2*MV_W-1:0] mv;
    } res_t;

    logic                        clk;
    logic                        rst;
    logic                        start;
    logic                        ref_ready;
    logic [NUM_PART*SAD_W-1:0]   sad_in;
    logic                        roll;
    logic signed [MV_W-1:0]      cand_x;
    logic signed [MV_W-1:0]      cand_y;
    logic                        busy;
    logic                        done;
    logic [NUM_PART*SAD_W-1:0]   best_sad;
    logic [NUM_PART*2*MV_W-1:0]  best_mv;

    ime_search_ctrl #(
        .SR     (SR),
        .MV_W   (MV_W),
        .SAD_W  (SAD_W),
        .PE_LAT (PE_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_ready (ref_ready),
        .sad_in    (sad_in),
        .roll      (roll),
        .cand_x    (cand_x),
        .cand_y    (cand_y),
        .busy      (busy),
        .done      (done),
        .best_sad  (best_sad),
        .best_mv   (best_mv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int mode = 0;
    bit gated = 1'b0;
    int s_cyc = 0;
    int nrolls = 0;
    int ndone = 0;
    logic [2*MV_W-1:0] cand_q [$];
    res_t              res_q  [$];
    res_t              r_exp;
    logic [2*MV_W:0]   smp = '0;
    logic [2*MV_W:0]   h [PE_LAT];
    logic [MV_W-1:0]   mvmin;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sad_of(input int m, input int p, input int x, input int y);
        case (m)
            0:       return iabs(x - 3) + iabs(y + 2);
            1:       return 100;
            default: return iabs(x - (p - 4)) + iabs(y - (3 - p)) + 7 * p;
        endcase
    endfunction

    function automatic res_t model(input int m);
        res_t r;
        int   best [NUM_PART];
        int   s;
        r = '0;
        for (int p = 0; p < NUM_PART; p++) best[p] = (1 << SAD_W) - 1;
        for (int y = -SR; y < SR; y++) begin
            for (int x = -SR; x < SR; x++) begin
                for (int p = 0; p < NUM_PART; p++) begin
                    s = sad_of(m, p, x, y);
                    if (s < best[p]) begin
                        best[p] = s;
                        r.mv[p*2*MV_W +: 2*MV_W] = {y[MV_W-1:0], x[MV_W-1:0]};
                    end
                end
            end
        end
        for (int p = 0; p < NUM_PART; p++) r.sad[p*SAD_W +: SAD_W] = best[p][SAD_W-1:0];
        return r;
    endfunction

    // PE array stand-in: SAD appears PE_LAT cycles after the roll it belongs to.
    always @(posedge clk) begin
        logic [2*MV_W:0] e;
        int sx;
        int sy;
        #1;
        if (rst) begin
            for (int i = 0; i < PE_LAT; i++) h[i] = '0;
        end else begin
            for (int i = PE_LAT-1; i > 0; i--) h[i] = h[i-1];
            h[0] = smp;
        end
        ref_ready = gated ? cyc[0] : 1'b1;
        e = h[PE_LAT-1];
        sad_in = '0;
        if (e[2*MV_W]) begin
            sx = $signed(e[MV_W-1:0]);
            sy = $signed(e[2*MV_W-1:MV_W]);
            for (int p = 0; p < NUM_PART; p++)
                sad_in[p*SAD_W +: SAD_W] = SAD_W'(sad_of(mode, p, sx, sy));
        end
    end

    always @(negedge clk) begin
        smp = {roll & ~rst, cand_y, cand_x};
        if (busy) chk("roll_gate", roll & ~ref_ready, 0);
        if (roll) begin
            nrolls++;
            if (cand_q.size() == 0) chk("extra_roll", roll, 0);
            else chk("cand", {cand_y, cand_x}, cand_q.pop_front());
        end
        if (done) begin
            ndone++;
            if (res_q.size() == 0) begin
                chk("done_unexp", done, 0);
            end else begin
                r_exp = res_q.pop_front();
                chk("rolls", nrolls, NCAND);
                if (!gated) chk("done_cyc", cyc - s_cyc, NCAND + PE_LAT + 1);
                for (int p = 0; p < NUM_PART; p++) begin
                    chk($sformatf("sad%0d", p), best_sad[p*SAD_W +: SAD_W],
                        r_exp.sad[p*SAD_W +: SAD_W]);
                    chk($sformatf("mv%0d", p), best_mv[p*2*MV_W +: 2*MV_W],
                        r_exp.mv[p*2*MV_W +: 2*MV_W]);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_roll"}, roll, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cand"}, {cand_y, cand_x}, {mvmin, mvmin});
        chk({tag, "_bsad"}, best_sad, {(NUM_PART*SAD_W){1'b1}});
        chk({tag, "_bmv"}, best_mv, 0);
    endtask

    task automatic run(input int m, input bit g, input int second_at, input int abort_at);
        int d0;
        int t;
        bit fired;
        mode   = m;
        gated  = g;
        nrolls = 0;
        fired  = 1'b0;
        for (int y = -SR; y < SR; y++)
            for (int x = -SR; x < SR; x++)
                cand_q.push_back({y[MV_W-1:0], x[MV_W-1:0]});
        res_q.push_back(model(m));
        d0 = ndone;
        @(posedge clk);
        #1 start = 1'b1;
        s_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        t = 0;
        while (ndone == d0 && t < 3000) begin
            @(negedge clk);
            #2;
            t++;
            start = 1'b0;
            if (second_at >= 0 && !fired && nrolls >= second_at) begin
                start = 1'b1;
                fired = 1'b1;
            end
            if (abort_at >= 0 && nrolls >= abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_vals("abort");
                cand_q.delete();
                res_q.delete();
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (30) @(negedge clk);
                chk("abort_no_done", ndone - d0, 0);
                chk("abort_idle", busy, 0);
                return;
            end
        end
        chk("done_seen", ndone - d0, 1);
        repeat (6) @(negedge clk);
        chk("idle_after", busy, 0);
        chk("single_done", ndone - d0, 1);
        chk("q_empty", cand_q.size(), 0);
    endtask

    initial begin
        mvmin = MV_W'(-SR);
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_vals("idle");

        run(0, 1'b0, -1, -1);
        run(1, 1'b0, -1, -1);
        run(2, 1'b0, -1, -1);
        run(0, 1'b1, -1, -1);
        run(2, 1'b0, 50, -1);
        run(0, 1'b0, -1, 100);
        run(1, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ime_search_ctrl.md
Name: ime_search_ctrl

Overview:
- Sequences the 16x16 PE array through a full-search window for one macroblock.
- Issues one roll per candidate position and presents the candidate motion vector to the reference fetch unit.
- Tracks the minimum SAD and its motion vector for 9 partitions: 1x 16x16, 2x 16x8, 2x 8x16, 4x 8x8.
- Sits between the macroblock scheduler (start/done) and the PE array plus reference-window buffer.

Parameters:
- SR, 8: search range; candidate MV x,y each span [-SR, SR-1], giving (2*SR)^2 candidates.
- MV_W, 6: signed MV component width; must hold -SR and SR-1.
- SAD_W, 16: width of each incoming partition SAD.
- PE_LAT, 2: cycles from roll being sampled high to the matching SAD being valid at sad_in; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a search; honoured only in IDLE.
- ref_ready  in  1  reference buffer holds data for cand_mv; roll fires only when this is high.
- sad_in  in  9*SAD_W  partition SADs, packed. Index order: 0=FF, 1-2=F8[0..1], 3-4=8F[0..1], 5-8=88[0][0],[0][1],[1][0],[1][1].
- roll  out  1  advance the PE array to the next candidate.
- cand_x, cand_y  out  MV_W each  signed candidate MV for the current roll.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when results are final.
- best_sad  out  9*SAD_W  minimum SAD per partition.
- best_mv  out  9*2*MV_W  per partition {y,x} of the best candidate.

Behaviour:
- Reset values: roll=0, busy=0, done=0, cand_x=cand_y=-SR, best_sad all ones, best_mv all zero, state=IDLE, tag pipeline cleared.
- IDLE -> SEARCH when start=1.
  - Candidate counter loads (-SR, -SR).
  - best_sad is set to all ones and best_mv to zero.
- SEARCH: roll = ref_ready, combinational AND with the state; cand_x/cand_y are registered.
  - On each roll, the counter advances raster-wise: x increments; when x = SR-1, x wraps to -SR and y increments.
  - ref_ready=0 stalls the counter with no roll. Outputs hold.
  - Roll issued with (SR-1, SR-1) -> DRAIN.
- Tag pipeline: depth PE_LAT, holding {valid, cand_y, cand_x}.
  - Entry is written with valid=roll each cycle.
  - The head entry qualifies sad_in.
- Compare rule, per partition p, when the head is valid:
  - if sad_in[p] < best_sad[p] (unsigned, strict), update best_sad[p] and best_mv[p] from the head tag.
  - Ties keep the earlier candidate in raster order.
  - All 9 comparisons run in parallel in one cycle.
- DRAIN: no roll; stays until the tag pipeline has no valid entry -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
  - best_* hold until the next accepted start.
- start in SEARCH, DRAIN or DONE is ignored; there is no queueing.
- start in the same cycle that DONE returns to IDLE is ignored. start is sampled only while in IDLE.
- rst asserted mid-search aborts immediately to reset values. No done pulse is produced.
- Total latency with ref_ready held high:
  - start accepted at edge 0;
  - rolls on cycles 1..N, where N=(2*SR)^2;
  - done on cycle N+PE_LAT+1.

Decomposition:
- Package ime_pkg:
  - partition index constants (P_FF, P_F8_0, ... P_88_11, NUM_PART=9);
  - the state enum (IDLE, SEARCH, DRAIN, DONE);
  - the MV struct {y,x}.
- One natural sub-module, ime_min_tracker: a single-partition compare/update register.
  - Parameters: SAD_W, MV_W.
  - Ports: clk, rst, clear, valid, sad, mv, best_sad, best_mv.
  - Instantiated 9 times.

Test Plan:
- Reset then idle, no start:
  - roll=0, busy=0, done=0;
  - best_sad = 0xFFFF for all 9 partitions;
  - cand = (-8, -8).
- SR=8, PE_LAT=2, ref_ready=1:
  - a single start gives exactly 256 roll cycles;
  - cand runs (-8,-8), (-7,-8) ... (7,-8), (-8,-7) ... (7,7);
  - done is asserted on cycle 259 after start.
- Model returns SAD = |x-3| + |y+2| for every partition: all best_mv = (3,-2), best_sad = 0.
- Constant SAD = 100 for all candidates: best_mv = (-8,-8) under the tie rule, best_sad = 100.
- ref_ready toggled 1,0,1,0 throughout:
  - roll appears only on ready cycles;
  - 256 rolls in total;
  - cand never skips a position;
  - results match the ungated run.
- Mid-operation events:
  - rst asserted at roll 100 gives immediate reset values with no done;
  - a second start during SEARCH is ignored, and only one done follows 256 rolls.
